// File: rtl/led_pkg.sv
// led_pkg: scan states, default panel geometry and width helpers
// shared by the HUB75 scan sequencer and its BCM timer.
package led_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY,
    S_BLANK
  } scan_state_t;

  localparam int DEF_COLS   = 32;
  localparam int DEF_ROWS   = 16;
  localparam int DEF_PLANES = 4;

  // Never returns 0 so single-entry dimensions still get a 1-bit field.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W   = width_of(DEF_ROWS);
  localparam int COL_W   = width_of(DEF_COLS);
  localparam int PLANE_W = width_of(DEF_PLANES);

endpackage

// File: rtl/led_bcm_timer.sv
// led_bcm_timer: loadable down-counter timing the DISPLAY and BLANK
// intervals; done is high on the last cycle of a loaded interval.
module led_bcm_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: HUB75 row scanner -- shift one bit-plane, latch,
// select the row, then hold OE for a BCM-weighted time.
module led_scan_sequencer
  import led_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int PLANES  = DEF_PLANES,
  parameter int DIV     = 1,
  parameter int BASE_OE = 8,
  parameter int BLANK   = 2,
  localparam int RW = width_of(ROWS),
  localparam int CW = width_of(COLS),
  localparam int PW = width_of(PLANES)
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  input  logic          EN_I,
  output logic [RW-1:0] ROW_O,
  output logic [CW-1:0] COL_O,
  output logic [PW-1:0] PLANE_O,
  input  logic [2:0]    RGB0_I,
  input  logic [2:0]    RGB1_I,
  output logic [2:0]    RGB0_O,
  output logic [2:0]    RGB1_O,
  output logic          CLK_O,
  output logic          LATCH_O,
  output logic          OE_N_O,
  output logic [RW-1:0] ROW_ADDR_O,
  output logic          FRAME_O
);

  localparam int DW   = width_of(DIV);
  localparam int DMAX = BASE_OE << (PLANES - 1);
  localparam int TMAX = (DMAX > BLANK) ? DMAX : BLANK;
  localparam int TW   = width_of(TMAX);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'((DIV > 1) ? DIV - 2 : 0);

  scan_state_t   state;
  logic          hi;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] col;

  logic          t_load;
  logic [TW-1:0] t_value;
  logic [TW-1:0] t_count;
  logic          t_done;

  logic [31:0]   disp_cycles;
  logic          col_end_next;
  logic          wrap;
  logic          frame_next;

  assign disp_cycles = 32'(BASE_OE) << PLANE_O;

  // Next cycle is the last of the column: present the next fetch address.
  assign col_end_next = (state == S_SHIFT) &&
    ((DIV == 1) ? !hi : (hi && div_cnt == DIV_PRE));

  assign wrap = (PLANE_O == PW'(PLANES - 1)) &&
                (ROW_O == RW'(ROWS - 1));

  assign frame_next = wrap && (
    (state == S_DISPLAY && t_done && BLANK == 1) ||
    (state == S_BLANK && t_count == TW'(1)));

  always_comb begin
    t_load  = 1'b0;
    t_value = '0;
    if (state == S_LATCH) begin
      t_load  = 1'b1;
      t_value = TW'(disp_cycles - 32'd1);
    end else if (state == S_DISPLAY && t_done) begin
      t_load  = 1'b1;
      t_value = TW'(BLANK - 1);
    end
  end

  led_bcm_timer #(.W(TW)) u_timer (
    .clk   (CLK_I),
    .rst_n (RST_N_I),
    .load  (t_load),
    .value (t_value),
    .count (t_count),
    .done  (t_done)
  );

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state      <= S_IDLE;
      hi         <= 1'b0;
      div_cnt    <= '0;
      col        <= '0;
      ROW_O      <= '0;
      COL_O      <= '0;
      PLANE_O    <= '0;
      RGB0_O     <= '0;
      RGB1_O     <= '0;
      CLK_O      <= 1'b0;
      LATCH_O    <= 1'b0;
      OE_N_O     <= 1'b1;
      ROW_ADDR_O <= '0;
      FRAME_O    <= 1'b0;
    end else begin
      LATCH_O <= 1'b0;
      FRAME_O <= frame_next;
      unique case (state)
        S_IDLE: begin
          if (EN_I) state <= S_PREFETCH;
        end
        S_PREFETCH: begin
          state   <= S_SHIFT;
          hi      <= 1'b0;
          div_cnt <= '0;
          col     <= '0;
        end
        S_SHIFT: begin
          if (!hi && div_cnt == '0) begin
            RGB0_O <= RGB0_I;
            RGB1_O <= RGB1_I;
          end
          if (col_end_next) COL_O <= COL_O + CW'(1);
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            hi      <= !hi;
            CLK_O   <= !hi;
            if (hi) begin
              col <= col + CW'(1);
              if (col == CW'(COLS - 1)) begin
                state      <= S_LATCH;
                LATCH_O    <= 1'b1;
                ROW_ADDR_O <= ROW_O;
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_LATCH: begin
          state  <= S_DISPLAY;
          OE_N_O <= 1'b0;
        end
        S_DISPLAY: begin
          if (t_done) begin
            state  <= S_BLANK;
            OE_N_O <= 1'b1;
          end
        end
        S_BLANK: begin
          if (t_done) begin
            if (PLANE_O == PW'(PLANES - 1)) begin
              PLANE_O <= '0;
              ROW_O   <= (ROW_O == RW'(ROWS - 1)) ? '0 : ROW_O + RW'(1);
            end else begin
              PLANE_O <= PLANE_O + PW'(1);
            end
            state <= EN_I ? S_PREFETCH : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_sequencer.sv
// tb_led_scan_sequencer: directed table plus hand sequences for the
// 4x2x2 scanner (DIV=1) and a DIV=3 copy for shift-clock timing.
module tb_led_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       en3;
  logic [0:0] row_o, plane_o, row_addr_o;
  logic [1:0] col_o;
  logic [2:0] rgb0_i, rgb1_i, rgb0_o, rgb1_o;
  logic       clk_o, latch_o, oe_n_o, frame_o;
  logic [0:0] d3_row_o, d3_plane_o, d3_row_addr_o;
  logic [1:0] d3_col_o;
  logic [2:0] d3_rgb0_i, d3_rgb1_i, d3_rgb0_o, d3_rgb1_o;
  logic       d3_clk_o, d3_latch_o, d3_oe_n_o, d3_frame_o;

  always #5 clk = ~clk;

  led_scan_sequencer #(
    .COLS(4), .ROWS(2), .PLANES(2),
    .DIV(1), .BASE_OE(4), .BLANK(2)
  ) u_dut (
    .CLK_I(clk), .RST_N_I(rst_n), .EN_I(en),
    .ROW_O(row_o), .COL_O(col_o), .PLANE_O(plane_o),
    .RGB0_I(rgb0_i), .RGB1_I(rgb1_i),
    .RGB0_O(rgb0_o), .RGB1_O(rgb1_o),
    .CLK_O(clk_o), .LATCH_O(latch_o), .OE_N_O(oe_n_o),
    .ROW_ADDR_O(row_addr_o), .FRAME_O(frame_o)
  );

  led_scan_sequencer #(
    .COLS(4), .ROWS(2), .PLANES(2),
    .DIV(3), .BASE_OE(4), .BLANK(2)
  ) u_div3 (
    .CLK_I(clk), .RST_N_I(rst_n), .EN_I(en3),
    .ROW_O(d3_row_o), .COL_O(d3_col_o), .PLANE_O(d3_plane_o),
    .RGB0_I(d3_rgb0_i), .RGB1_I(d3_rgb1_i),
    .RGB0_O(d3_rgb0_o), .RGB1_O(d3_rgb1_o),
    .CLK_O(d3_clk_o), .LATCH_O(d3_latch_o), .OE_N_O(d3_oe_n_o),
    .ROW_ADDR_O(d3_row_addr_o), .FRAME_O(d3_frame_o)
  );

  // Frame-buffer models: one cycle of read latency.
  always @(posedge clk) begin
    rgb0_i    <= 3'(col_o);
    rgb1_i    <= 3'd7 - 3'(col_o);
    d3_rgb0_i <= 3'(d3_col_o);
    d3_rgb1_i <= 3'd7 - 3'(d3_col_o);
  end

  typedef struct packed {
    logic       clk;
    logic       lat;
    logic       oe_n;
    logic       frame;
    logic [1:0] col;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
    logic       plane;
    logic       row;
    logic       ra;
  } obs_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  vec_t vecs[17];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;

  function automatic obs_t ob(input logic c, input logic l,
                              input logic e, input logic [1:0] cl,
                              input logic [2:0] r0,
                              input logic [2:0] r1,
                              input logic pl);
    obs_t o;
    o = '{clk: c, lat: l, oe_n: e, frame: 1'b0, col: cl,
          rgb0: r0, rgb1: r1, plane: pl, row: 1'b0, ra: 1'b0};
    return o;
  endfunction

  function automatic obs_t obs_now();
    obs_t o;
    o = '{clk: clk_o, lat: latch_o, oe_n: oe_n_o, frame: frame_o,
          col: col_o, rgb0: rgb0_o, rgb1: rgb1_o,
          plane: plane_o[0], row: row_o[0], ra: row_addr_o[0]};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event log and panel-safety watch on the DIV=1 instance.
  int   lat_ra[$], lat_t[$], oe_runs[$], frame_t[$];
  int   run = 0;
  int   viol = 0;
  int   clk_hi = 0;
  logic prev_ra = 1'b0;

  always @(negedge clk) begin
    if (latch_o) begin
      lat_ra.push_back(int'(row_addr_o));
      lat_t.push_back(cyc - t0);
    end
    if (frame_o) frame_t.push_back(cyc - t0);
    if (!oe_n_o) run++;
    else if (run > 0) begin
      oe_runs.push_back(run);
      run = 0;
    end
    if (clk_o) clk_hi++;
    if (latch_o && !oe_n_o) viol++;
    if (row_addr_o[0] !== prev_ra && !oe_n_o) viol++;
    if (clk_o && (latch_o || !oe_n_o)) viol++;
    prev_ra = row_addr_o[0];
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   nl, nr, h0, lat_at;
    int   rises[$], falls[$], rgbs[$];
    int   exp_ra[4], exp_run[4];
    logic prev;
    obs_t rst_obs;

    exp_ra  = '{0, 0, 1, 1};
    exp_run = '{4, 8, 4, 8};
    rst_obs = ob(0, 0, 1, 2'd0, 3'd0, 3'd0, 0);

    vecs[0]  = '{1'b1, ob(0, 0, 1, 2'd0, 3'd0, 3'd0, 0)};
    vecs[1]  = '{1'b1, ob(0, 0, 1, 2'd0, 3'd0, 3'd0, 0)};
    vecs[2]  = '{1'b1, ob(1, 0, 1, 2'd1, 3'd0, 3'd7, 0)};
    vecs[3]  = '{1'b1, ob(0, 0, 1, 2'd1, 3'd0, 3'd7, 0)};
    vecs[4]  = '{1'b1, ob(1, 0, 1, 2'd2, 3'd1, 3'd6, 0)};
    vecs[5]  = '{1'b1, ob(0, 0, 1, 2'd2, 3'd1, 3'd6, 0)};
    vecs[6]  = '{1'b1, ob(1, 0, 1, 2'd3, 3'd2, 3'd5, 0)};
    vecs[7]  = '{1'b1, ob(0, 0, 1, 2'd3, 3'd2, 3'd5, 0)};
    vecs[8]  = '{1'b1, ob(1, 0, 1, 2'd0, 3'd3, 3'd4, 0)};
    vecs[9]  = '{1'b1, ob(0, 1, 1, 2'd0, 3'd3, 3'd4, 0)};
    for (int i = 10; i < 14; i++)
      vecs[i] = '{1'b1, ob(0, 0, 0, 2'd0, 3'd3, 3'd4, 0)};
    vecs[14] = '{1'b1, ob(0, 0, 1, 2'd0, 3'd3, 3'd4, 0)};
    vecs[15] = '{1'b1, ob(0, 0, 1, 2'd0, 3'd3, 3'd4, 0)};
    vecs[16] = '{1'b1, ob(0, 0, 1, 2'd0, 3'd3, 3'd4, 1)};

    rst_n = 1'b0;
    en    = 1'b0;
    en3   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs_now()), 32'(rst_obs));
    chk("reset_d3_oe_n", 32'(d3_oe_n_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_outputs", 32'(obs_now()), 32'(rst_obs));

    // First row-plane, cycle by cycle.
    t0 = cyc;
    for (int i = 0; i < 17; i++) begin
      en = vecs[i].en;
      step();
      chk($sformatf("vec%0d", i + 1), 32'(obs_now()), 32'(vecs[i].exp));
    end

    // Free-run through two frames.
    for (int i = 0; i < 400 && frame_t.size() < 2; i++) step();
    chk("frame_count", 32'(frame_t.size()), 32'd2);
    if (frame_t.size() >= 2) begin
      chk("frame_first", 32'(frame_t[0]), 32'd72);
      chk("frame_period", 32'(frame_t[1] - frame_t[0]), 32'd72);
    end
    chk("latch_count_ok", 32'(lat_t.size() >= 4), 32'd1);
    chk("oe_run_count_ok", 32'(oe_runs.size() >= 4), 32'd1);
    if (lat_t.size() >= 4 && oe_runs.size() >= 4) begin
      chk("latch_first_cycle", 32'(lat_t[0]), 32'd10);
      chk("latch_second_cycle", 32'(lat_t[1]), 32'd26);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("latch_row_addr%0d", i), 32'(lat_ra[i]),
            32'(exp_ra[i]));
        chk($sformatf("oe_low_len%0d", i), 32'(oe_runs[i]),
            32'(exp_run[i]));
      end
    end

    // Drop EN mid-SHIFT: row 0 plane 0 completes, then IDLE.
    repeat (3) step();
    en = 1'b0;
    nl = lat_t.size();
    nr = oe_runs.size();
    repeat (40) step();
    chk("drop_latch_done", 32'(lat_t.size()), 32'(nl + 1));
    chk("drop_oe_runs", 32'(oe_runs.size()), 32'(nr + 1));
    if (oe_runs.size() > nr)
      chk("drop_oe_len", 32'(oe_runs[nr]), 32'd4);
    chk("idle_oe_n", 32'(oe_n_o), 32'd1);
    chk("idle_plane", 32'(plane_o), 32'd1);
    chk("idle_row", 32'(row_o), 32'd0);
    h0 = clk_hi;
    repeat (20) step();
    chk("idle_clk_quiet", 32'(clk_hi - h0), 32'd0);
    chk("idle_no_latch", 32'(lat_t.size()), 32'(nl + 1));

    // Resume from the stored plane.
    en = 1'b1;
    lat_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (latch_o) begin
        lat_at = i;
        break;
      end
    end
    chk("resume_latch_cycle", 32'(lat_at), 32'd10);
    chk("resume_plane", 32'(plane_o), 32'd1);
    chk("resume_row_addr", 32'(row_addr_o), 32'd0);

    // Asynchronous reset in the middle of DISPLAY.
    step();
    chk("display_oe_n", 32'(oe_n_o), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(obs_now()), 32'(rst_obs));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1)
        chk("post_reset_row_plane", 32'({row_o, plane_o}), 32'd0);
      if (latch_o) begin
        lat_at = i;
        break;
      end
    end
    chk("post_reset_latch_cycle", 32'(lat_at), 32'd10);

    // DIV=3 shift-clock timing.
    en3 = 1'b1;
    prev = d3_clk_o;
    lat_at = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (d3_clk_o && !prev) begin
        rises.push_back(i);
        rgbs.push_back(int'(d3_rgb0_o));
      end
      if (!d3_clk_o && prev) falls.push_back(i);
      prev = d3_clk_o;
      if (d3_latch_o) begin
        lat_at = i;
        break;
      end
    end
    chk("d3_latch_cycle", 32'(lat_at), 32'd26);
    chk("d3_rises", 32'(rises.size()), 32'd4);
    chk("d3_falls", 32'(falls.size()), 32'd4);
    if (rises.size() > 0)
      chk("d3_first_rise", 32'(rises[0]), 32'd5);
    for (int i = 0; i < rises.size() && i < falls.size(); i++) begin
      chk($sformatf("d3_high%0d", i), 32'(falls[i] - rises[i]), 32'd3);
      chk($sformatf("d3_rgb%0d", i), 32'(rgbs[i]), 32'(i));
      if (i > 0)
        chk($sformatf("d3_low%0d", i), 32'(rises[i] - falls[i - 1]),
            32'd3);
    end

    chk("panel_invariants", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
